// File: rtl/dcache_refill_unit_pkg.sv
// Shared sizes and FSM encoding for the L1 data cache refill unit.
// The critical-word-first option (DCACHE_REFILL_CWF_EN) is selected in the top module.
package dcache_refill_unit_pkg;

  localparam int DCACHE_ADDR_W           = 32;
  localparam int DCACHE_BLOCK_BITS       = 1024;
  localparam int DCACHE_BEAT_BITS        = 128;
  localparam int DCACHE_BEATS            = DCACHE_BLOCK_BITS / DCACHE_BEAT_BITS;
  localparam int DCACHE_OFFSET_BITS      = 7;
  localparam int DCACHE_BEAT_OFFSET_BITS = 4;
  localparam int DCACHE_BEAT_IDX_BITS    = $clog2(DCACHE_BEATS);
  localparam int DCACHE_MASK_BITS        = DCACHE_BLOCK_BITS / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    FILL    = 2'd2,
    RESOLVE = 2'd3
  } refill_state_t;

endpackage

// File: rtl/dcache_refill_unit_line_buffer.sv
// Block assembly buffer for the refill unit: one 128-bit slot per beat, written by
// slot index, cleared by the asynchronous active-low reset.
module refill_line_buffer
  import dcache_refill_unit_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_we,
  input  logic [DCACHE_BEAT_IDX_BITS-1:0] i_idx,
  input  logic [DCACHE_BEAT_BITS-1:0]     i_data,
  output logic [DCACHE_BLOCK_BITS-1:0]    o_block
);

  genvar gi;
  generate
    for (gi = 0; gi < DCACHE_BEATS; gi++) begin : g_slot
      logic [DCACHE_BEAT_BITS-1:0] r_slot;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_slot <= '0;
        end else if (i_we && (i_idx == DCACHE_BEAT_IDX_BITS'(gi))) begin
          r_slot <= i_data;
        end
      end

      assign o_block[gi*DCACHE_BEAT_BITS +: DCACHE_BEAT_BITS] = r_slot;
    end
  endgenerate

endmodule

// File: rtl/dcache_refill_unit.sv
// L1 data cache miss-repair engine: accepts one read/write miss at a time, fetches the
// block in 128-bit beats and returns it. Define DCACHE_REFILL_CWF_EN for critical word first.
module dcache_refill_unit
  import dcache_refill_unit_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read_repair_request,
  input  logic [DCACHE_ADDR_W-1:0]     missed_raddr,
  output logic                         read_repair_req_acq,
  input  logic                         write_repair_request,
  input  logic [DCACHE_ADDR_W-1:0]     missed_waddr,
  output logic                         write_repair_req_acq,
  output logic                         repair_resolved,
  output logic [DCACHE_ADDR_W-1:0]     fill_addr,
  output logic [DCACHE_BLOCK_BITS-1:0] fill_data,
  output logic [DCACHE_MASK_BITS-1:0]  fill_wmask,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [DCACHE_ADDR_W-1:0]     mem_req_addr,
  input  logic                         mem_rsp_valid,
  input  logic [DCACHE_BEAT_BITS-1:0]  mem_rsp_data
);

  refill_state_t                   r_state;
  logic [DCACHE_ADDR_W-1:0]        r_addr;
  logic [DCACHE_ADDR_W-1:0]        r_mem_req_addr;
  logic [DCACHE_BEAT_IDX_BITS-1:0] r_idx;
  logic [DCACHE_BEAT_IDX_BITS-1:0] r_cnt;
  logic                            r_read_acq;
  logic                            r_write_acq;
  logic                            r_resolved;
  logic                            r_mem_req_valid;

  logic [DCACHE_ADDR_W-1:0]        w_sel_addr;
  logic [DCACHE_ADDR_W-1:0]        w_mem_addr;
  logic [DCACHE_BEAT_IDX_BITS-1:0] w_start_beat;
  logic [DCACHE_BLOCK_BITS-1:0]    w_block;
  logic                            w_beat_we;
  logic                            w_unused_offset;

  // Read wins when both misses are presented in the same IDLE cycle.
  assign w_sel_addr = read_repair_request ? missed_raddr : missed_waddr;

`ifdef DCACHE_REFILL_CWF_EN
  assign w_mem_addr   = {w_sel_addr[DCACHE_ADDR_W-1:DCACHE_BEAT_OFFSET_BITS],
                         {DCACHE_BEAT_OFFSET_BITS{1'b0}}};
  assign w_start_beat = r_addr[DCACHE_OFFSET_BITS-1:DCACHE_BEAT_OFFSET_BITS];
`else
  assign w_mem_addr   = {w_sel_addr[DCACHE_ADDR_W-1:DCACHE_OFFSET_BITS],
                         {DCACHE_OFFSET_BITS{1'b0}}};
  assign w_start_beat = '0;
`endif

  assign w_unused_offset = ^r_addr[DCACHE_OFFSET_BITS-1:0];
  assign w_beat_we       = (r_state == FILL) && mem_rsp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_mem_req_addr  <= '0;
      r_idx           <= '0;
      r_cnt           <= '0;
      r_read_acq      <= 1'b0;
      r_write_acq     <= 1'b0;
      r_resolved      <= 1'b0;
      r_mem_req_valid <= 1'b0;
    end else begin
      r_read_acq  <= 1'b0;
      r_write_acq <= 1'b0;
      r_resolved  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (read_repair_request || write_repair_request) begin
            r_addr          <= w_sel_addr;
            r_mem_req_addr  <= w_mem_addr;
            r_mem_req_valid <= 1'b1;
            r_read_acq      <= read_repair_request;
            r_write_acq     <= ~read_repair_request;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (r_mem_req_valid && mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_idx           <= w_start_beat;
            r_cnt           <= '0;
            r_state         <= FILL;
          end
        end
        FILL: begin
          // Slot index wraps so a critical-word-first burst lands in natural order.
          if (mem_rsp_valid) begin
            r_idx <= r_idx + 1'b1;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == DCACHE_BEAT_IDX_BITS'(DCACHE_BEATS - 1)) begin
              r_resolved <= 1'b1;
              r_state    <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  refill_line_buffer u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_beat_we),
    .i_idx   (r_idx),
    .i_data  (mem_rsp_data),
    .o_block (w_block)
  );

  assign read_repair_req_acq  = r_read_acq;
  assign write_repair_req_acq = r_write_acq;
  assign repair_resolved      = r_resolved;
  assign mem_req_valid        = r_mem_req_valid;
  assign mem_req_addr         = r_mem_req_addr;
  assign fill_addr            = r_resolved
                              ? {r_addr[DCACHE_ADDR_W-1:DCACHE_OFFSET_BITS], {DCACHE_OFFSET_BITS{1'b0}}}
                              : '0;
  assign fill_data            = r_resolved ? w_block : '0;
  assign fill_wmask           = {DCACHE_MASK_BITS{r_resolved}};

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed self-checking bench for dcache_refill_unit (honours DCACHE_REFILL_CWF_EN if defined).
`timescale 1ns/1ps
module tb_dcache_refill_unit;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            read_repair_request = 1'b0;
  logic [31:0]     missed_raddr = '0;
  logic            read_repair_req_acq;
  logic            write_repair_request = 1'b0;
  logic [31:0]     missed_waddr = '0;
  logic            write_repair_req_acq;
  logic            repair_resolved;
  logic [31:0]     fill_addr;
  logic [1023:0]   fill_data;
  logic [127:0]    fill_wmask;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [31:0]     mem_req_addr;
  logic            mem_rsp_valid = 1'b0;
  logic [127:0]    mem_rsp_data = '0;

  always #5 clk = ~clk;

  dcache_refill_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .read_repair_request  (read_repair_request),
    .missed_raddr         (missed_raddr),
    .read_repair_req_acq  (read_repair_req_acq),
    .write_repair_request (write_repair_request),
    .missed_waddr         (missed_waddr),
    .write_repair_req_acq (write_repair_req_acq),
    .repair_resolved      (repair_resolved),
    .fill_addr            (fill_addr),
    .fill_data            (fill_data),
    .fill_wmask           (fill_wmask),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_addr         (mem_req_addr),
    .mem_rsp_valid        (mem_rsp_valid),
    .mem_rsp_data         (mem_rsp_data)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int res_total = 0;

  always @(negedge clk) if (repair_resolved === 1'b1) res_total++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [127:0] beat_val(input int seed, input int k);
    logic [31:0] w;
    w = (32'(seed) << 8) | 32'(k);
    return {4{w}};
  endfunction

  function automatic int start_of(input logic [31:0] a);
`ifdef DCACHE_REFILL_CWF_EN
    return int'(a[6:4]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_mem_addr(input logic [31:0] a);
`ifdef DCACHE_REFILL_CWF_EN
    return {a[31:4], 4'h0};
`else
    return {a[31:7], 7'h00};
`endif
  endfunction

  // Called in cycle 0 with the request already driven; runs the memory side of one fill.
  task automatic serve(input logic is_write, input logic [31:0] addr, input int ready_lat,
                       input int gap, input int seed, input logic junk_in_req, input string nm,
                       output int acq_cyc, output int res_cyc);
    int n;
    int start;
    logic early;
    acq_cyc = -1;
    res_cyc = -1;
    n = 0;
    while (((is_write ? write_repair_req_acq : read_repair_req_acq) !== 1'b1) && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) begin
      check({nm, "_acq_timeout"}, 128'(0), 128'(1));
      read_repair_request  = 1'b0;
      write_repair_request = 1'b0;
      return;
    end
    acq_cyc = cyc;
    if (is_write) write_repair_request = 1'b0;
    else          read_repair_request  = 1'b0;
    check({nm, "_other_acq"}, 128'(is_write ? read_repair_req_acq : write_repair_req_acq), 128'(0));
    check({nm, "_req_valid"}, 128'(mem_req_valid), 128'(1));
    check({nm, "_req_addr"}, 128'(mem_req_addr), 128'(exp_mem_addr(addr)));
    for (int i = 0; i < ready_lat; i++) begin
      if (junk_in_req) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = '1;
      end
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      check({nm, "_req_hold_valid"}, 128'(mem_req_valid), 128'(1));
      check({nm, "_req_hold_addr"}, 128'(mem_req_addr), 128'(exp_mem_addr(addr)));
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check({nm, "_req_dropped"}, 128'(mem_req_valid), 128'(0));
    start = start_of(addr);
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = beat_val(seed, (start + i) % 8);
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (i < 7) begin
        early = early | repair_resolved;
        for (int g = 0; g < gap; g++) begin
          step();
          early = early | repair_resolved;
        end
      end
    end
    check({nm, "_no_early_resolve"}, 128'(early), 128'(0));
    check({nm, "_resolved"}, 128'(repair_resolved), 128'(1));
    res_cyc = cyc;
    check({nm, "_fill_addr"}, 128'(fill_addr), 128'({addr[31:7], 7'h00}));
    check({nm, "_fill_wmask"}, fill_wmask, {128{1'b1}});
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_beat%0d", nm, k), fill_data[k*128 +: 128], beat_val(seed, k));
    end
    step();
    check({nm, "_resolved_pulse"}, 128'(repair_resolved), 128'(0));
    check({nm, "_wmask_clear"}, fill_wmask, 128'(0));
    check({nm, "_fill_addr_clear"}, 128'(fill_addr), 128'(0));
  endtask

  initial begin : main
    int a_cyc, r_cyc, a2_cyc, r2_cyc, base, n;

    // Reset state
    step();
    step();
    check("rst_acq_rd", 128'(read_repair_req_acq), 128'(0));
    check("rst_resolved", 128'(repair_resolved), 128'(0));
    check("rst_req_valid", 128'(mem_req_valid), 128'(0));
    check("rst_req_addr", 128'(mem_req_addr), 128'(0));
    check("rst_wmask", fill_wmask, 128'(0));
    check("rst_fill_any", 128'(|fill_data), 128'(0));
    rst = 1'b1;
    step();

    // Minimum-latency read fill
    read_repair_request = 1'b1;
    missed_raddr = 32'h0000_1234;
    cyc = 0;
    serve(1'b0, 32'h0000_1234, 0, 0, 1, 1'b0, "rd_min", a_cyc, r_cyc);
    check("rd_min_acq_cycle", 128'(a_cyc), 128'(1));
    check("rd_min_res_cycle", 128'(r_cyc), 128'(10));
    step();

    // Simultaneous read and write: read first, write after one IDLE cycle
    read_repair_request  = 1'b1;
    missed_raddr         = 32'h0000_0100;
    write_repair_request = 1'b1;
    missed_waddr         = 32'h0000_2080;
    cyc = 0;
    serve(1'b0, 32'h0000_0100, 0, 0, 2, 1'b0, "dual_rd", a_cyc, r_cyc);
    serve(1'b1, 32'h0000_2080, 0, 0, 3, 1'b0, "dual_wr", a2_cyc, r2_cyc);
    check("dual_wr_acq_gap", 128'(a2_cyc - r_cyc), 128'(2));
    step();

    // Backpressure and gapped beats
    base = res_total;
    read_repair_request = 1'b1;
    missed_raddr = 32'h0000_5A40;
    cyc = 0;
    serve(1'b0, 32'h0000_5A40, 5, 2, 4, 1'b0, "slow", a_cyc, r_cyc);
    step();
    check("slow_one_resolve", 128'(res_total - base), 128'(1));

    // Unaligned address (critical-word-first order when enabled)
    read_repair_request = 1'b1;
    missed_raddr = 32'h0000_1274;
    cyc = 0;
    serve(1'b0, 32'h0000_1274, 0, 0, 1, 1'b0, "cwf", a_cyc, r_cyc);
    step();

    // Reset after four beats
    base = res_total;
    read_repair_request = 1'b1;
    missed_raddr = 32'h0000_3300;
    n = 0;
    while (read_repair_req_acq !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("rstmid_acq", 128'(read_repair_req_acq), 128'(1));
    read_repair_request = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = beat_val(5, i);
      step();
    end
    mem_rsp_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_req_valid", 128'(mem_req_valid), 128'(0));
    check("rstmid_resolved", 128'(repair_resolved), 128'(0));
    check("rstmid_wmask", fill_wmask, 128'(0));
    check("rstmid_fill_any", 128'(|fill_data), 128'(0));
    step();
    step();
    rst = 1'b1;
    for (int i = 4; i < 8; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = beat_val(5, i);
      step();
    end
    mem_rsp_valid = 1'b0;
    step();
    check("rstmid_no_resolve", 128'(res_total - base), 128'(0));
    read_repair_request = 1'b1;
    missed_raddr = 32'h0000_3300;
    cyc = 0;
    serve(1'b0, 32'h0000_3300, 0, 0, 6, 1'b0, "post_rst", a_cyc, r_cyc);
    step();

    // Stray response beats in IDLE and REQ
    base = res_total;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = '1;
    step();
    step();
    mem_rsp_valid = 1'b0;
    check("stray_idle_no_resolve", 128'(res_total - base), 128'(0));
    write_repair_request = 1'b1;
    missed_waddr = 32'h0000_7F80;
    cyc = 0;
    serve(1'b1, 32'h0000_7F80, 3, 0, 7, 1'b1, "stray", a_cyc, r_cyc);
    step();
    check("stray_one_resolve", 128'(res_total - base), 128'(1));

    check("total_resolves", 128'(res_total), 128'(7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
